// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: requester-side and memory-side bus of the shared memory-port arbiter
interface mem_arbiter_rr_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LINE_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ-1:0]        resp_err;
    logic [LINE_W-1:0]         resp_data;
    logic                      mem_req_valid;
    logic                      mem_req_we;
    logic [ADDR_W-1:0]         mem_req_addr;
    logic [LINE_W-1:0]         mem_req_data;
    logic                      mem_resp_valid;
    logic [LINE_W-1:0]         mem_resp_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_data, mem_resp_valid, mem_resp_data,
        output grant, resp_valid, resp_err, resp_data,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_data, mem_resp_valid, mem_resp_data,
        input  grant, resp_valid, resp_err, resp_data,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_data
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-way fixed/round-robin arbiter for one shared memory port, one transaction in flight
module mem_arbiter_rr #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_arbiter_rr_if.slave bus,
    output logic            timeout_flag
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win;
    logic [CW-1:0] wd_cnt;
    logic          done;
    logic          abort;

    // Reverse scan so the last hit is the first requester at or after base.
    function automatic logic [IW-1:0] pick(input logic [NUM_REQ-1:0] req, input logic [IW-1:0] base);
        logic [IW-1:0] w;
        w = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[(int'(base) + k) % NUM_REQ]) w = IW'((int'(base) + k) % NUM_REQ);
        return w;
    endfunction

    assign win   = pick(bus.req_valid, RR_MODE != 0 ? rr_ptr : '0);
    assign done  = state == WAIT && bus.mem_resp_valid;
    assign abort = state == WAIT && !bus.mem_resp_valid && TIMEOUT != 0 && wd_cnt == WD_LAST;

    assign bus.resp_valid = done ? bus.grant : '0;
    assign bus.resp_err   = abort ? bus.grant : '0;
    assign bus.resp_data  = done ? bus.mem_resp_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            owner             <= '0;
            rr_ptr            <= '0;
            wd_cnt            <= '0;
            timeout_flag      <= 1'b0;
            bus.grant         <= '0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_we    <= 1'b0;
            bus.mem_req_addr  <= '0;
            bus.mem_req_data  <= '0;
        end else begin
            bus.mem_req_valid <= 1'b0;
            case (state)
                IDLE: if (|bus.req_valid) begin
                    state             <= ISSUE;
                    owner             <= win;
                    bus.grant         <= NUM_REQ'(1) << win;
                    bus.mem_req_valid <= 1'b1;
                    bus.mem_req_we    <= bus.req_we[win];
                    bus.mem_req_addr  <= bus.req_addr[int'(win) * ADDR_W +: ADDR_W];
                    bus.mem_req_data  <= bus.req_data[int'(win) * LINE_W +: LINE_W];
                end
                ISSUE: begin
                    state  <= WAIT;
                    wd_cnt <= '0;
                end
                default: if (done || abort) begin
                    state     <= IDLE;
                    bus.grant <= '0;
                    rr_ptr    <= IW'((int'(owner) + 1) % NUM_REQ);
                    if (abort) timeout_flag <= 1'b1;
                end else if (wd_cnt != '1) begin
                    wd_cnt <= wd_cnt + CW'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: randomized transaction-level check of a round-robin and a fixed-priority arbiter
module tb_mem_arbiter_rr;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_rr_if #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW)) b0 ();
    mem_arbiter_rr_if #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW)) b1 ();
    logic tf0, tf1;

    mem_arbiter_rr #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1), .TIMEOUT(TO)) dut_rr (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave), .timeout_flag(tf0));
    mem_arbiter_rr #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(0), .TIMEOUT(TO)) dut_fx (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave), .timeout_flag(tf1));

    logic [N-1:0]  rv [2];
    logic [N-1:0]  we [2];
    logic [AW-1:0] ad [2][N];
    logic [LW-1:0] dt [2][N];
    logic          mv [2];
    logic [LW-1:0] md [2];

    assign b0.req_valid      = rv[0];
    assign b1.req_valid      = rv[1];
    assign b0.req_we         = we[0];
    assign b1.req_we         = we[1];
    assign b0.mem_resp_valid = mv[0];
    assign b1.mem_resp_valid = mv[1];
    assign b0.mem_resp_data  = md[0];
    assign b1.mem_resp_data  = md[1];
    for (genvar g = 0; g < N; g++) begin : g_pay
        assign b0.req_addr[g*AW +: AW] = ad[0][g];
        assign b1.req_addr[g*AW +: AW] = ad[1][g];
        assign b0.req_data[g*LW +: LW] = dt[0][g];
        assign b1.req_data[g*LW +: LW] = dt[1][g];
    end

    logic [N-1:0]  gn [2];
    logic [N-1:0]  ro [2];
    logic [N-1:0]  re [2];
    logic [LW-1:0] rd [2];
    logic          qv [2];
    logic          qw [2];
    logic [AW-1:0] qa [2];
    logic [LW-1:0] qd [2];
    logic          tf [2];

    assign gn[0] = b0.grant;         assign gn[1] = b1.grant;
    assign ro[0] = b0.resp_valid;    assign ro[1] = b1.resp_valid;
    assign re[0] = b0.resp_err;      assign re[1] = b1.resp_err;
    assign rd[0] = b0.resp_data;     assign rd[1] = b1.resp_data;
    assign qv[0] = b0.mem_req_valid; assign qv[1] = b1.mem_req_valid;
    assign qw[0] = b0.mem_req_we;    assign qw[1] = b1.mem_req_we;
    assign qa[0] = b0.mem_req_addr;  assign qa[1] = b1.mem_req_addr;
    assign qd[0] = b0.mem_req_data;  assign qd[1] = b1.mem_req_data;
    assign tf[0] = tf0;              assign tf[1] = tf1;

    int checks = 0;
    int failures = 0;
    int ptr [2];
    bit tflag [2];
    logic [LW-1:0] rdat;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: first requester at or after base, wrapping.
    function automatic int pick(input logic [N-1:0] m, input int base);
        for (int k = 0; k < N; k++)
            if (m[(base + k) % N]) return (base + k) % N;
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic rand_payload(input int u);
        we[u] = N'($urandom);
        for (int i = 0; i < N; i++) begin
            ad[u][i] = $urandom;
            dt[u][i] = rand_line();
        end
    endtask

    task automatic check_all_zero(input int u, input string tag);
        check({tag, "_gnt"}, LW'(gn[u]), '0);
        check({tag, "_mqv"}, LW'(qv[u]), '0);
        check({tag, "_mqwe"}, LW'(qw[u]), '0);
        check({tag, "_mqaddr"}, LW'(qa[u]), '0);
        check({tag, "_mqdata"}, qd[u], '0);
        check({tag, "_resp"}, LW'({ro[u], re[u]}), '0);
        check({tag, "_rdata"}, rd[u], '0);
        check({tag, "_tflag"}, LW'(tf[u]), '0);
    endtask

    // One transaction from IDLE; memory answers d cycles after ISSUE (d > TO means silent until abort).
    task automatic txn(input int u, input logic [N-1:0] mask, input int d, input bit spur);
        int w, last;
        logic [N-1:0] oh;
        w = pick(mask, u == 0 ? ptr[0] : 0);
        oh = N'(1) << w;
        last = d <= TO ? d : TO;
        next_cycle();
        rv[u] = mask;
        mv[u] = 1'b0;
        @(negedge clk);
        check("idle_gnt", LW'(gn[u]), '0);
        next_cycle();
        mv[u] = spur;
        md[u] = rand_line();
        @(negedge clk);
        check("iss_valid", LW'(qv[u]), 1);
        check("iss_gnt", LW'(gn[u]), LW'(oh));
        check("iss_we", LW'(qw[u]), LW'(we[u][w]));
        check("iss_addr", LW'(qa[u]), LW'(ad[u][w]));
        check("iss_data", qd[u], dt[u][w]);
        check("iss_noresp", LW'({ro[u], re[u]}), '0);
        for (int k = 1; k <= last; k++) begin
            next_cycle();
            mv[u] = k == d;
            md[u] = k == d ? rdat : rand_line();
            if (k == last) rv[u] = '0;
            @(negedge clk);
            if (k < last) begin
                check("wait_gnt", LW'(gn[u]), LW'(oh));
                check("wait_mqv", LW'(qv[u]), '0);
                check("wait_addr", LW'(qa[u]), LW'(ad[u][w]));
                check("wait_data", qd[u], dt[u][w]);
                check("wait_noresp", LW'({ro[u], re[u]}), '0);
            end else if (d <= TO) begin
                check("resp_valid", LW'(ro[u]), LW'(oh));
                check("resp_data", rd[u], rdat);
                check("resp_noerr", LW'(re[u]), '0);
            end else begin
                check("abort_err", LW'(re[u]), LW'(oh));
                check("abort_noresp", LW'(ro[u]), '0);
            end
        end
        ptr[u] = (w + 1) % N;
        if (d > TO) tflag[u] = 1'b1;
        for (int k = TO + 1; k <= d; k++) begin
            next_cycle();
            mv[u] = k == d;
            @(negedge clk);
            check("late_ignored", LW'({gn[u], ro[u], re[u]}), '0);
        end
        next_cycle();
        mv[u] = 1'b0;
        @(negedge clk);
        check("post_gnt", LW'(gn[u]), '0);
        check("post_tflag", LW'(tf[u]), LW'(tflag[u]));
    endtask

    initial begin
        int issues, last_cyc, cyc, w;
        bit pend;
        for (int u = 0; u < 2; u++) begin
            rv[u] = '0;
            mv[u] = 1'b0;
            md[u] = '0;
            ptr[u] = 0;
            tflag[u] = 1'b0;
            rand_payload(u);
        end
        rdat = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero(0, "rst_rr");
        check_all_zero(1, "rst_fx");
        next_cycle();
        rst_n = 1'b1;

        // Single read, response 4 cycles after issue
        we[0][0] = 1'b0;
        ad[0][0] = 32'h100;
        rdat = {16{8'hA5}};
        txn(0, 4'b0001, 4, 1'b0);

        // Write from requester 1
        we[0][1] = 1'b1;
        ad[0][1] = 32'h2000;
        dt[0][1] = {8{16'hDEAD}};
        rdat = rand_line();
        txn(0, 4'b0010, 3, 1'b0);

        // Watchdog abort with late response, then normal service
        txn(0, 4'b0001, 10, 1'b0);
        txn(0, 4'b0001, 2, 1'b1);

        // Fixed priority
        txn(1, 4'b1110, 2, 1'b0);
        repeat (3) txn(1, 4'b1111, 1, 1'b0);

        // Two requesters held continuously, memory answers one cycle after issue
        next_cycle();
        rv[0] = 4'b0011;
        issues = 0;
        last_cyc = -1;
        cyc = 0;
        pend = 1'b0;
        while (issues < 8 && cyc < 60) begin
            @(negedge clk);
            pend = qv[0];
            if (qv[0]) begin
                w = pick(4'b0011, ptr[0]);
                check("alt_gnt", LW'(gn[0]), LW'(N'(1) << w));
                if (last_cyc >= 0) check("alt_gap", LW'(cyc - last_cyc), 3);
                last_cyc = cyc;
                issues++;
                ptr[0] = (w + 1) % N;
            end
            next_cycle();
            mv[0] = pend;
            cyc++;
        end
        check("alt_count", LW'(issues), 8);
        rv[0] = '0;
        next_cycle();
        mv[0] = 1'b0;

        // Randomized transactions on both arbiters
        for (int i = 0; i < 80; i++) begin
            int u;
            u = $urandom_range(0, 1);
            rand_payload(u);
            rdat = rand_line();
            txn(u, N'($urandom_range(1, 15)), $urandom_range(1, 10), $urandom_range(0, 3) == 0);
        end

        // No requests: stray response has no effect
        next_cycle();
        rv[0] = '0;
        mv[0] = 1'b1;
        @(negedge clk);
        check("idle_stray", LW'({gn[0], ro[0], re[0]}), '0);
        next_cycle();
        mv[0] = 1'b0;
        @(negedge clk);
        check("idle_stay", LW'(gn[0]), '0);

        // Async reset in WAIT with a nonzero round-robin pointer
        txn(0, 4'b0100, 1, 1'b0);
        txn(0, 4'b0001, 9, 1'b0);
        next_cycle();
        rv[0] = 4'b1111;
        next_cycle();
        next_cycle();
        #2 rst_n = 1'b0;
        #1;
        check_all_zero(0, "arst_rr");
        check_all_zero(1, "arst_fx");
        ptr[0] = 0;
        ptr[1] = 0;
        tflag[0] = 1'b0;
        tflag[1] = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        rv[0] = '0;
        mv[0] = 1'b1;
        @(negedge clk);
        check("spurious_resp", LW'({gn[0], ro[0], re[0]}), '0);
        next_cycle();
        mv[0] = 1'b0;
        rdat = rand_line();
        txn(0, 4'b1111, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
